div7_feeder: RTL



---
 rtl/div7_pkg.sv | 19 +
 rtl/div7_op_fifo.sv | 62 ++++++
 rtl/div7_feeder.sv | 123 ++++++++++++
 3 files changed

// File: rtl/div7_pkg.sv
// Shared constants and FSM encoding for the divide-by-7 operand feeder.
package div7_pkg;

    localparam int DATA_W        = 16;
    localparam int Q_W           = 14;
    localparam int R_W           = 4;
    localparam int DIV_CYCLES    = 16;
    localparam int DEPTH_DEFAULT = 4;
    // Watchdog default leaves eight cycles of slack over the divider's run time.
    localparam int WDOG_DEFAULT  = DIV_CYCLES + 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

endpackage

// File: rtl/div7_op_fifo.sv
// Operand FIFO: DEPTH x DATA_W, wrap-around pointers, occupancy count.
// Push is ignored when full and pop is ignored when empty.
module div7_op_fifo
    import div7_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push_i,
    input  logic [DATA_W-1:0]         wr_data_i,
    input  logic                      pop_i,
    output logic [DATA_W-1:0]         rd_data_o,
    output logic                      full_o,
    output logic                      empty_o,
    output logic [$clog2(DEPTH):0]    level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     count_q, count_d;
    logic              do_push, do_pop;

    assign full_o    = (count_q == LW'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign level_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];
    assign do_push   = push_i && !full_o;
    assign do_pop    = pop_i && !empty_o;

    // Next pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        count_d = count_q + LW'(do_push) - LW'(do_pop);
    end

    // Storage array is not reset; only valid entries are ever read.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
    end

    // Pointer and count registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/div7_feeder.sv
// Operand queue and sequencer in front of the serial divide-by-7 unit.
// Both streams use valid/ready: a transfer happens on a rising edge where
// valid and ready are both high; valid, once raised, holds its payload
// stable until that transfer.
module div7_feeder
    import div7_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int WDOG  = WDOG_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [15:0]            in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [13:0]            out_q,
    output logic [3:0]             out_rem,
    output logic                   div_start,
    output logic [15:0]            div_data,
    input  logic                   div_busy,
    input  logic                   div_valid,
    input  logic [13:0]            div_q,
    input  logic [3:0]             div_rem,
    output logic                   err_timeout,
    output logic [$clog2(DEPTH):0] level,
    output logic [1:0]             dbg_state
);

    localparam int WW = $clog2(WDOG + 1);

    state_e            state_q;
    logic              div_start_q;
    logic [DATA_W-1:0] div_data_q;
    logic              out_valid_q;
    logic [Q_W-1:0]    out_q_q;
    logic [R_W-1:0]    out_rem_q;
    logic              err_timeout_q;
    logic [WW-1:0]     wdog_q;

    logic              fifo_full, fifo_empty, fifo_pop;
    logic [DATA_W-1:0] fifo_head;

    // The divider's busy flag is observed only; sequencing relies on the FSM.
    logic div_busy_unused;
    assign div_busy_unused = div_busy;

    assign fifo_pop = (state_q == ST_IDLE) && !fifo_empty;

    div7_op_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_i    (in_valid),
        .wr_data_i (in_data),
        .pop_i     (fifo_pop),
        .rd_data_o (fifo_head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .level_o   (level)
    );

    assign in_ready    = !fifo_full;
    assign div_start   = div_start_q;
    assign div_data    = div_data_q;
    assign out_valid   = out_valid_q;
    assign out_q       = out_q_q;
    assign out_rem     = out_rem_q;
    assign err_timeout = err_timeout_q;
    assign dbg_state   = state_q;

    // Sequencer FSM with registered divider strobe, result register and watchdog.
    // HOLD always lasts at least one cycle, so no start follows a done pulse directly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            div_start_q   <= 1'b0;
            div_data_q    <= '0;
            out_valid_q   <= 1'b0;
            out_q_q       <= '0;
            out_rem_q     <= '0;
            err_timeout_q <= 1'b0;
            wdog_q        <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        div_data_q  <= fifo_head;
                        div_start_q <= 1'b1;
                        state_q     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    div_start_q <= 1'b0;
                    wdog_q      <= '0;
                    state_q     <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (div_valid) begin
                        out_q_q     <= div_q;
                        out_rem_q   <= div_rem;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_HOLD;
                    end else if (wdog_q == WW'(WDOG - 1)) begin
                        // Divider never answered: flag it and drop the operand.
                        err_timeout_q <= 1'b1;
                        state_q       <= ST_IDLE;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
